// File: rtl/conv_event_queue_if.sv
// Event bus between the upstream encoder, the event queue and the convolution stage.
//
// Handshake rules:
//   Ingress : an event transfers on a rising clk edge where in_valid && in_ready.
//             in_ready is low whenever the queue is full; the producer must hold
//             in_valid and its fields stable until the transfer happens.
//   Egress  : event_out is meaningful only while event_valid is high, and it is
//             held stable until consumed. A one-cycle event_ack pulse at an edge
//             where event_valid is high consumes the head. An ack while
//             event_valid is low has no effect.
interface conv_event_queue_if #(
  parameter int COORD_BITS    = 8,
  parameter int IN_CHANNELS   = 2,
  parameter int TIMESTEP_BITS = 8
);
  localparam int EW = TIMESTEP_BITS + 2 * COORD_BITS + IN_CHANNELS;

  logic                   in_valid;
  logic                   in_ready;
  logic [COORD_BITS-1:0]  in_x;
  logic [COORD_BITS-1:0]  in_y;
  logic [IN_CHANNELS-1:0] in_spikes;
  logic [EW-1:0]          event_out;
  logic                   event_valid;
  logic                   event_ack;

  // Producer/consumer side (encoder plus convolution stage, or a bench).
  modport master (
    output in_valid, in_x, in_y, in_spikes, event_ack,
    input  in_ready, event_out, event_valid
  );

  // The event queue itself.
  modport slave (
    input  in_valid, in_x, in_y, in_spikes, event_ack,
    output in_ready, event_out, event_valid
  );
endinterface

// File: rtl/conv_event_queue.sv
// Event buffer in front of the 2D convolution stage.
// Filters out events with no active channel or with out-of-range coordinates,
// stamps survivors with the current timestep and queues them in a FIFO whose
// head is presented on a registered valid/ack port.
module conv_event_queue #(
  parameter int          IN_CHANNELS   = 2,
  parameter int unsigned IMG_WIDTH     = 32,
  parameter int unsigned IMG_HEIGHT    = 32,
  parameter int          COORD_BITS    = 8,
  parameter int          TIMESTEP_BITS = 8,
  parameter int          FIFO_DEPTH    = 16,
  parameter int          CNT_BITS      = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  conv_event_queue_if.slave             bus,
  input  logic                          timestep_tick,
  output logic [$clog2(FIFO_DEPTH):0]   occupancy,
  output logic [TIMESTEP_BITS-1:0]      timestep,
  output logic [CNT_BITS-1:0]           empty_drop_count,
  output logic [CNT_BITS-1:0]           range_err_count
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int EW = TIMESTEP_BITS + 2 * COORD_BITS + IN_CHANNELS;
  localparam logic [PW:0] FULL_CNT = (PW + 1)'(FIFO_DEPTH);

  // Storage and FIFO control state.
  logic [EW-1:0]            mem [FIFO_DEPTH];
  logic [PW-1:0]            wr_ptr;
  logic [PW-1:0]            rd_ptr;
  logic [PW:0]              count;
  logic [TIMESTEP_BITS-1:0] ts_q;
  logic [CNT_BITS-1:0]      empty_cnt_q;
  logic [CNT_BITS-1:0]      range_cnt_q;

  // Registered view of the head.
  logic                     valid_q;
  logic [EW-1:0]            out_q;

  // Per-cycle decode.
  logic                     in_ready_w;
  logic                     in_hs;
  logic                     range_err;
  logic                     empty_spk;
  logic                     do_push;
  logic                     do_pop;
  logic [EW-1:0]            new_entry;
  logic [PW-1:0]            rd_ptr_next;
  logic [PW:0]              count_next;
  logic [EW-1:0]            head_next;

  // Full blocks intake even in a cycle that pops; space reopens the cycle after.
  assign in_ready_w = (count != FULL_CNT);
  assign in_hs      = bus.in_valid && in_ready_w;

  // Range errors win over empty-spike drops, so each event bumps one counter.
  assign range_err  = (32'(bus.in_x) >= IMG_WIDTH) || (32'(bus.in_y) >= IMG_HEIGHT);
  assign empty_spk  = (bus.in_spikes == '0);
  assign do_push    = in_hs && !range_err && !empty_spk;

  // Acks are only meaningful against a presented head.
  assign do_pop     = bus.event_ack && valid_q;

  // Stamp with the pre-increment timestep, even when a tick lands this cycle.
  assign new_entry  = {ts_q, bus.in_x, bus.in_y, bus.in_spikes};

  // Compute where the head will be after this edge so the output can be registered.
  always_comb begin
    rd_ptr_next = rd_ptr;
    count_next  = count;
    head_next   = '0;
    if (do_pop) begin
      rd_ptr_next = rd_ptr + PW'(1);
    end
    case ({do_push, do_pop})
      2'b10:   count_next = count + (PW + 1)'(1);
      2'b01:   count_next = count - (PW + 1)'(1);
      default: count_next = count;
    endcase
    // The slot being written this edge is the next head only when the queue
    // would otherwise be empty afterwards; bypass it so latency stays one cycle.
    if (do_push && (wr_ptr == rd_ptr_next)) begin
      head_next = new_entry;
    end else begin
      head_next = mem[rd_ptr_next];
    end
  end

  // Entry storage; no reset needed since occupancy gates every read.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= new_entry;
    end
  end

  // Pointers, occupancy and the registered head view.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      valid_q <= 1'b0;
      out_q   <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      rd_ptr  <= rd_ptr_next;
      count   <= count_next;
      valid_q <= (count_next != '0);
      out_q   <= (count_next != '0) ? head_next : '0;
    end
  end

  // Timestep counter, wraps naturally at its width.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ts_q <= '0;
    end else if (timestep_tick) begin
      ts_q <= ts_q + TIMESTEP_BITS'(1);
    end
  end

  // Saturating drop counters for filtered events.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      empty_cnt_q <= '0;
      range_cnt_q <= '0;
    end else if (in_hs) begin
      if (range_err) begin
        if (range_cnt_q != '1) begin
          range_cnt_q <= range_cnt_q + CNT_BITS'(1);
        end
      end else if (empty_spk) begin
        if (empty_cnt_q != '1) begin
          empty_cnt_q <= empty_cnt_q + CNT_BITS'(1);
        end
      end
    end
  end

  assign bus.in_ready    = in_ready_w;
  assign bus.event_valid = valid_q;
  assign bus.event_out   = out_q;

  assign occupancy        = count;
  assign timestep         = ts_q;
  assign empty_drop_count = empty_cnt_q;
  assign range_err_count  = range_cnt_q;

endmodule

// File: tb/tb_conv_event_queue.sv
// Directed bench for conv_event_queue: stimulus pushes expected events into a
// scoreboard queue; a negedge monitor compares the presented head against it.
module tb_conv_event_queue;

  localparam int EW = 26;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        timestep_tick;
  logic [4:0]  occupancy;
  logic [7:0]  timestep;
  logic [15:0] empty_drop_count;
  logic [15:0] range_err_count;

  conv_event_queue_if #(.COORD_BITS(8), .IN_CHANNELS(2), .TIMESTEP_BITS(8)) bus ();

  conv_event_queue #(
    .IN_CHANNELS(2), .IMG_WIDTH(32), .IMG_HEIGHT(32), .COORD_BITS(8),
    .TIMESTEP_BITS(8), .FIFO_DEPTH(16), .CNT_BITS(16)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .bus              (bus),
    .timestep_tick    (timestep_tick),
    .occupancy        (occupancy),
    .timestep         (timestep),
    .empty_drop_count (empty_drop_count),
    .range_err_count  (range_err_count)
  );

  // Clock and watchdog.
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got timeout required finish");
    $fatal(1, "watchdog");
  end

  int errors = 0;
  int checks = 0;
  logic [EW-1:0] exp_q[$];
  logic [7:0] ts_model;
  logic last_acc;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", name, act, req);
    end
  endtask

  // One clock of stimulus; the model decides acceptance from in_ready just before the edge.
  task automatic step(input logic v, input logic [7:0] x, input logic [7:0] y,
                      input logic [1:0] sp, input logic ack, input logic tick);
    bus.in_valid  = v;
    bus.in_x      = x;
    bus.in_y      = y;
    bus.in_spikes = sp;
    bus.event_ack = ack;
    timestep_tick = tick;
    @(negedge clk);
    last_acc = v && bus.in_ready;
    if (last_acc && x < 8'd32 && y < 8'd32 && sp != 2'b00) begin
      exp_q.push_back({ts_model, x, y, sp});
    end
    if (tick) ts_model = ts_model + 8'd1;
    @(posedge clk);
    #1;
    bus.in_valid  = 1'b0;
    bus.in_x      = '0;
    bus.in_y      = '0;
    bus.in_spikes = '0;
    bus.event_ack = 1'b0;
    timestep_tick = 1'b0;
  endtask

  // Scoreboard monitor: the presented head must match the oldest expected event.
  always @(negedge clk) begin
    if (rst_n && bus.event_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL spurious_valid: got event_out %0h required no valid event", bus.event_out);
      end else begin
        chk("head_data", 32'(bus.event_out), 32'(exp_q[0]));
        if (bus.event_ack) void'(exp_q.pop_front());
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    ts_model = 8'd0;
    last_acc = 1'b0;
    bus.in_valid = 1'b0; bus.in_x = '0; bus.in_y = '0; bus.in_spikes = '0;
    bus.event_ack = 1'b0; timestep_tick = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    // Reset state.
    chk("rst_occ", 32'(occupancy), 0);
    chk("rst_valid", 32'(bus.event_valid), 0);
    chk("rst_out", 32'(bus.event_out), 0);
    chk("rst_ts", 32'(timestep), 0);
    chk("rst_empty_cnt", 32'(empty_drop_count), 0);
    chk("rst_range_cnt", 32'(range_err_count), 0);
    chk("rst_ready", 32'(bus.in_ready), 1);

    // Single event, one-cycle latency, then ack.
    step(1'b1, 8'd5, 8'd3, 2'b11, 1'b0, 1'b0);
    chk("t1_valid", 32'(bus.event_valid), 1);
    chk("t1_out", 32'(bus.event_out), 32'({8'd0, 8'd5, 8'd3, 2'b11}));
    step(1'b0, 8'd0, 8'd0, 2'b00, 1'b1, 1'b0);
    chk("t1_valid_after_ack", 32'(bus.event_valid), 0);
    chk("t1_occ_after_ack", 32'(occupancy), 0);

    // Fill to full, hold the 17th, pop once, then drain across pointer wrap.
    for (int i = 0; i < 16; i++) step(1'b1, 8'(i), 8'(15 - i), 2'(i % 3 + 1), 1'b0, 1'b0);
    chk("t2_occ_full", 32'(occupancy), 16);
    chk("t2_ready_full", 32'(bus.in_ready), 0);
    step(1'b1, 8'd20, 8'd21, 2'b10, 1'b0, 1'b0);
    chk("t2_held_occ", 32'(occupancy), 16);
    step(1'b1, 8'd20, 8'd21, 2'b10, 1'b1, 1'b0);
    chk("t2_pop_while_full_occ", 32'(occupancy), 15);
    chk("t2_ready_after_pop", 32'(bus.in_ready), 1);
    step(1'b1, 8'd20, 8'd21, 2'b10, 1'b0, 1'b0);
    chk("t2_17th_accepted", 32'(occupancy), 16);
    repeat (16) step(1'b0, 8'd0, 8'd0, 2'b00, 1'b1, 1'b0);
    chk("t2_drained_occ", 32'(occupancy), 0);
    chk("t2_drained_valid", 32'(bus.event_valid), 0);
    chk("t2_all_popped", exp_q.size(), 0);

    // Filtering: empty spikes and out-of-range coordinates.
    step(1'b1, 8'd1, 8'd1, 2'b00, 1'b0, 1'b0);
    step(1'b1, 8'd32, 8'd0, 2'b01, 1'b0, 1'b0);
    step(1'b1, 8'd40, 8'd40, 2'b00, 1'b0, 1'b0);
    chk("t3_empty_cnt", 32'(empty_drop_count), 1);
    chk("t3_range_cnt", 32'(range_err_count), 2);
    chk("t3_occ", 32'(occupancy), 0);
    chk("t3_valid", 32'(bus.event_valid), 0);

    // Timestamp on a tick cycle, then wrap.
    repeat (7) step(1'b0, 8'd0, 8'd0, 2'b00, 1'b0, 1'b1);
    chk("t4_ts7", 32'(timestep), 7);
    step(1'b1, 8'd9, 8'd9, 2'b01, 1'b0, 1'b1);
    chk("t4_ts8", 32'(timestep), 8);
    chk("t4_stamp", 32'(bus.event_out), 32'({8'd7, 8'd9, 8'd9, 2'b01}));
    step(1'b0, 8'd0, 8'd0, 2'b00, 1'b1, 1'b0);
    repeat (248) step(1'b0, 8'd0, 8'd0, 2'b00, 1'b0, 1'b1);
    chk("t4_ts_wrap", 32'(timestep), 0);

    // Steady occupancy with simultaneous push and pop.
    for (int i = 0; i < 3; i++) step(1'b1, 8'(10 + i), 8'(i), 2'b10, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      step(1'b1, 8'(i + 1), 8'(2 * i), 2'b01, 1'b1, 1'b0);
      chk("t5_occ_steady", 32'(occupancy), 3);
      chk("t5_valid_steady", 32'(bus.event_valid), 1);
    end
    repeat (3) step(1'b0, 8'd0, 8'd0, 2'b00, 1'b1, 1'b0);
    chk("t5_drained", 32'(occupancy), 0);
    step(1'b0, 8'd0, 8'd0, 2'b00, 1'b1, 1'b0);
    chk("t5_stray_ack_occ", 32'(occupancy), 0);
    chk("t5_stray_ack_valid", 32'(bus.event_valid), 0);
    step(1'b1, 8'd2, 8'd2, 2'b01, 1'b1, 1'b0);
    chk("t5_push_stray_ack_occ", 32'(occupancy), 1);
    step(1'b0, 8'd0, 8'd0, 2'b00, 1'b1, 1'b0);
    chk("t5_final_occ", 32'(occupancy), 0);

    // Asynchronous reset mid-stream.
    for (int i = 0; i < 5; i++) step(1'b1, 8'(i), 8'(i + 1), 2'b11, 1'b0, 1'b1);
    chk("t6_occ5", 32'(occupancy), 5);
    chk("t6_ts5", 32'(timestep), 5);
    rst_n = 1'b0;
    exp_q.delete();
    ts_model = 8'd0;
    #1;
    chk("t6_async_valid", 32'(bus.event_valid), 0);
    chk("t6_async_occ", 32'(occupancy), 0);
    chk("t6_async_ts", 32'(timestep), 0);
    chk("t6_async_empty_cnt", 32'(empty_drop_count), 0);
    chk("t6_async_range_cnt", 32'(range_err_count), 0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    chk("t6_ready_after_release", 32'(bus.in_ready), 1);
    step(1'b1, 8'd3, 8'd4, 2'b10, 1'b0, 1'b0);
    chk("t6_post_out", 32'(bus.event_out), 32'({8'd0, 8'd3, 8'd4, 2'b10}));
    step(1'b0, 8'd0, 8'd0, 2'b00, 1'b1, 1'b0);
    chk("t6_post_occ", 32'(occupancy), 0);
    chk("final_queue_empty", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/conv_event_queue.md
Name: conv_event_queue

Overview:
- Event buffer directly upstream of the 2D convolution stage.
- Accepts per-pixel spike events from the previous layer or input encoder and filters out events with no active channel or with out-of-range coordinates.
- Stamps each stored event with the current timestep and holds it in a FIFO.
- Presents the FIFO head to the convolution stage over its event_valid/event_ack handshake, absorbing bursts while the convolution walks kernel BRAM.

Parameters:
IN_CHANNELS, 2, spike bits per event (one per input channel)
IMG_WIDTH, 32, valid x range 0..IMG_WIDTH-1
IMG_HEIGHT, 32, valid y range 0..IMG_HEIGHT-1
COORD_BITS, 8, width of x and y fields
TIMESTEP_BITS, 8, width of timestep field
FIFO_DEPTH, 16, entries; power of two, at least 2
CNT_BITS, 16, width of the drop and error counters

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  upstream event valid
in_ready  output  1  queue can accept; equals not full
in_x  input  COORD_BITS  event x coordinate
in_y  input  COORD_BITS  event y coordinate
in_spikes  input  IN_CHANNELS  per-channel spike bits
timestep_tick  input  1  one-cycle pulse; advance timestep counter
event_out  output  TIMESTEP_BITS+2*COORD_BITS+IN_CHANNELS  packed {timestep, x, y, spikes}; field order matches output_vector_t in snn_interfaces_pkg
event_valid  output  1  event_out holds a valid FIFO head
event_ack  input  1  one-cycle pulse from convolution; consume head
occupancy  output  $clog2(FIFO_DEPTH)+1  stored entries
timestep  output  TIMESTEP_BITS  current timestep counter
empty_drop_count  output  CNT_BITS  events discarded because in_spikes == 0
range_err_count  output  CNT_BITS  events discarded because of out-of-range coordinates

Behaviour:
- Reset (async, rst_n low):
  - FIFO pointers and occupancy are 0.
  - event_valid = 0, event_out = 0, timestep = 0, both counters = 0.
  - in_ready = 1 the cycle after rst_n deasserts.
  - Reset mid-operation discards all stored entries; no partial event is ever presented.
- Accept:
  - A handshake occurs on a rising clk edge with in_valid && in_ready.
  - Accepted events are classified as follows:
    - x >= IMG_WIDTH or y >= IMG_HEIGHT: discarded; range_err_count increments.
    - Otherwise, in_spikes == 0: discarded; empty_drop_count increments.
    - Otherwise: written at the write pointer as {timestep, x, y, spikes}.
  - A range error takes priority over an empty-spike drop; only one counter increments per event.
  - Both counters saturate at 2^CNT_BITS-1.
- Timestamp:
  - An event accepted in the same cycle as timestep_tick carries the pre-increment timestep.
  - The timestep counter increments on the tick and wraps from 2^TIMESTEP_BITS-1 to 0.
- Output:
  - event_valid and event_out are registered from FIFO state.
  - An event written at edge N drives event_valid=1 after edge N, i.e. visible in the cycle following the write. Write-to-valid latency is 1 cycle.
  - event_out holds stable while event_valid=1 and no ack has arrived.
- Pop:
  - event_ack high at an edge while event_valid=1 removes the head.
  - If further entries remain, the next head appears after that edge with event_valid still 1; the valid/data transition is back-to-back with no bubble.
  - If the FIFO becomes empty, event_valid drops to 0 after that edge.
  - event_ack while event_valid=0 is ignored: no pointer or occupancy change.
- Simultaneous push and pop:
  - Occupancy is unchanged; both pointers advance.
  - When empty, a push plus a stray ack leaves occupancy at 1, because the ack is ignored.
- Full:
  - in_ready = 0 whenever occupancy == FIFO_DEPTH, including cycles where event_ack pops. in_ready rises the cycle after the pop.
  - Upstream must hold its event; nothing is silently lost.
- Wrap-around:
  - Pointers are $clog2(FIFO_DEPTH) bits and wrap naturally.
  - Ordering is strictly FIFO across wrap.
- No state machine beyond FIFO control.
- Counters and the timestep are readable at all times.

Test Plan:
- Reset, then push {x=5,y=3,spikes=2'b11} at timestep 0 -> event_valid=1 one cycle after the write, event_out={0,5,3,2'b11}; ack pulse -> event_valid=0 next cycle, occupancy=0.
- Push 16 valid events with no ack -> occupancy=16, in_ready=0; 17th event is held upstream; one ack -> in_ready=1 next cycle, 17th accepted; all 17 popped in push order across pointer wrap.
- Push spikes=0 at (1,1), then x=IMG_WIDTH with spikes=2'b01, then x=40,y=40 with spikes=0 -> empty_drop_count=1, range_err_count=2, occupancy=0, event_valid never asserts.
- Push in the same cycle as timestep_tick with timestep=7 -> stored timestep=7, counter reads 8; tick 248 more times -> counter wraps to 0.
- Hold occupancy=3 with continuous push and ack every cycle -> occupancy stays 3, event_valid never drops, output order is preserved; an ack with event_valid=0 changes nothing.
- Assert rst_n low mid-stream with occupancy=5 -> event_valid=0 immediately (async), occupancy=0, counters=0; normal operation after release.
